// File: rtl/sync_fifo_flags.sv
// ============================================================================
//  Module   : sync_fifo_flags
//  Purpose  : Single-clock FIFO with registered fill count, almost-full/empty
//             thresholds, selectable FWFT read mode and sticky error flags.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_fifo_flags #(
  parameter int DSIZE    = 8,
  parameter int ASIZE    = 4,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4,
  parameter int FWFT     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rinc,
  input  logic             clr_err,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             walmost_full,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int             DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] C_DEPTH = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] C_AF    = (ASIZE+1)'(AF_LEVEL);
  localparam logic [ASIZE:0] C_AE    = (ASIZE+1)'(AE_LEVEL);
  localparam logic [ASIZE:0] C_ONE   = (ASIZE+1)'(1);
  localparam logic [ASIZE-1:0] C_PTR_ONE = ASIZE'(1);

  logic [DSIZE-1:0] r_mem [DEPTH];
  logic [ASIZE-1:0] r_wptr;
  logic [ASIZE-1:0] r_rptr;
  logic [ASIZE:0]   r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_full;
  logic             w_empty;
  logic             w_wr_ok;
  logic             w_rd_ok;
  logic [ASIZE:0]   w_count_nxt;

  // All status is decoded from the registered count, so no input reaches an
  // output combinationally and same-cycle read/write cannot rescue a blocked op.
  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);
  assign w_wr_ok = winc && !w_full;
  assign w_rd_ok = rinc && !w_empty;

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_wr_ok, w_rd_ok})
      2'b10:   w_count_nxt = r_count + C_ONE;
      2'b01:   w_count_nxt = r_count - C_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + C_PTR_ONE;
      if (w_rd_ok) r_rptr <= r_rptr + C_PTR_ONE;
      r_count <= w_count_nxt;
      // Set has priority over clear when both happen in one cycle.
      if (winc && w_full)  r_overflow <= 1'b1;
      else if (clr_err)    r_overflow <= 1'b0;
      if (rinc && w_empty) r_underflow <= 1'b1;
      else if (clr_err)    r_underflow <= 1'b0;
    end
  end

  // Storage array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_wr_ok && !rst) r_mem[r_wptr] <= wdata;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata = r_mem[r_rptr];
    end else begin : g_std
      logic [DSIZE-1:0] r_rdata;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_rdata <= '0;
        else if (w_rd_ok) r_rdata <= r_mem[r_rptr];
      end
      assign rdata = r_rdata;
    end
  endgenerate

  assign wfull         = w_full;
  assign rempty        = w_empty;
  assign walmost_full  = (r_count >= C_AF);
  assign ralmost_empty = (r_count <= C_AE);
  assign count         = r_count;
  assign overflow      = r_overflow;
  assign underflow     = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_flags.sv
// ============================================================================
//  Module   : tb_sync_fifo_flags
//  Purpose  : Directed self-checking bench for sync_fifo_flags (std and FWFT).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       rst;
  // standard-read instance
  logic       winc, rinc, clr_err;
  logic [7:0] wdata, rdata;
  logic       wfull, rempty, waf, rae, ovf, unf;
  logic [4:0] count;
  // FWFT instance
  logic       winc1, rinc1, clr1;
  logic [7:0] wdata1, rdata1;
  logic       wfull1, rempty1, waf1, rae1, ovf1, unf1;
  logic [4:0] count1;

  int errors = 0;
  int checks = 0;
  logic [7:0] q[$];
  logic [7:0] exp_d;

  always #5 clk = ~clk;

  sync_fifo_flags #(.DSIZE(8), .ASIZE(4), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(0)) u_dut0 (
    .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .rinc(rinc), .clr_err(clr_err),
    .rdata(rdata), .wfull(wfull), .rempty(rempty), .walmost_full(waf),
    .ralmost_empty(rae), .count(count), .overflow(ovf), .underflow(unf));

  sync_fifo_flags #(.DSIZE(8), .ASIZE(4), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(1)) u_dut1 (
    .clk(clk), .rst(rst), .winc(winc1), .wdata(wdata1), .rinc(rinc1), .clr_err(clr1),
    .rdata(rdata1), .wfull(wfull1), .rempty(rempty1), .walmost_full(waf1),
    .ralmost_empty(rae1), .count(count1), .overflow(ovf1), .underflow(unf1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    winc = 0; rinc = 0; clr_err = 0; wdata = 8'h00;
    winc1 = 0; rinc1 = 0; clr1 = 0; wdata1 = 8'h00;
    tick(); tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_rempty", 32'(rempty), 1);
    chk("rst_wfull", 32'(wfull), 0);
    chk("rst_rae", 32'(rae), 1);
    chk("rst_waf", 32'(waf), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_unf", 32'(unf), 0);
    chk("rst_rdata", 32'(rdata), 0);
    rst = 1'b0;

    // 1. fill 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      winc = 1; wdata = 8'(i);
      tick();
      chk("fill_count", 32'(count), 32'(i));
      chk("fill_rae", 32'(rae), (i <= 4) ? 1 : 0);
      chk("fill_waf", 32'(waf), (i >= 12) ? 1 : 0);
      chk("fill_wfull", 32'(wfull), (i == 16) ? 1 : 0);
      chk("fill_ovf", 32'(ovf), 0);
    end

    // 2. overflow, clear, drain
    wdata = 8'hAA;
    tick();
    winc = 0;
    chk("ovf_count", 32'(count), 16);
    chk("ovf_set", 32'(ovf), 1);
    clr_err = 1;
    tick();
    clr_err = 0;
    chk("ovf_clr", 32'(ovf), 0);
    for (int i = 1; i <= 16; i++) begin
      rinc = 1;
      tick();
      chk("drain_rdata", 32'(rdata), 32'(i));
      chk("drain_count", 32'(count), 32'(16 - i));
    end
    rinc = 0;
    chk("drain_rempty", 32'(rempty), 1);

    // 3. underflow with simultaneous clear: set wins
    rinc = 1; clr_err = 1;
    tick();
    rinc = 0; clr_err = 0;
    chk("unf_set", 32'(unf), 1);
    chk("unf_count", 32'(count), 0);
    chk("unf_rdata_hold", 32'(rdata), 32'h10);
    clr_err = 1;
    tick();
    clr_err = 0;
    chk("unf_clr", 32'(unf), 0);

    // 4. concurrent read/write at count=8, pointers wrap
    for (int i = 0; i < 8; i++) begin
      winc = 1; wdata = 8'(8'h20 + i); q.push_back(wdata);
      tick();
    end
    chk("rw_start_count", 32'(count), 8);
    for (int k = 0; k < 20; k++) begin
      winc = 1; rinc = 1; wdata = 8'(8'h28 + k);
      exp_d = q.pop_front();
      q.push_back(wdata);
      tick();
      chk("rw_count", 32'(count), 8);
      chk("rw_rdata", 32'(rdata), 32'(exp_d));
    end
    rinc = 0;
    for (int i = 0; i < 8; i++) begin
      winc = 1; wdata = 8'(8'h50 + i); q.push_back(wdata);
      tick();
    end
    winc = 0;
    chk("refill_wfull", 32'(wfull), 1);

    // 5. full with simultaneous read: read wins, write rejected
    winc = 1; rinc = 1; wdata = 8'hBB;
    exp_d = q.pop_front();
    tick();
    winc = 0; rinc = 0;
    chk("fullrw_count", 32'(count), 15);
    chk("fullrw_ovf", 32'(ovf), 1);
    chk("fullrw_rdata", 32'(rdata), 32'(exp_d));
    clr_err = 1; tick(); clr_err = 0;
    for (int i = 0; i < 15; i++) begin
      rinc = 1;
      exp_d = q.pop_front();
      tick();
      chk("drain2_rdata", 32'(rdata), 32'(exp_d));
    end
    rinc = 0;
    chk("drain2_rempty", 32'(rempty), 1);
    // empty with simultaneous write: write wins, read rejected
    winc = 1; rinc = 1; wdata = 8'hCC;
    tick();
    winc = 0; rinc = 0;
    chk("emptyrw_count", 32'(count), 1);
    chk("emptyrw_unf", 32'(unf), 1);
    chk("emptyrw_rdata_hold", 32'(rdata), 32'(exp_d));
    rinc = 1;
    tick();
    rinc = 0;
    chk("emptyrw_read", 32'(rdata), 32'hCC);
    chk("emptyrw_count0", 32'(count), 0);

    // 6. FWFT instance
    winc1 = 1; wdata1 = 8'h5A;
    tick();
    winc1 = 0;
    chk("fwft_rempty", 32'(rempty1), 0);
    chk("fwft_rdata", 32'(rdata1), 32'h5A);
    rinc1 = 1;
    tick();
    rinc1 = 0;
    chk("fwft_empty", 32'(rempty1), 1);
    for (int i = 0; i < 6; i++) begin
      winc1 = 1; wdata1 = 8'(8'h61 + i);
      tick();
    end
    winc1 = 0;
    chk("fwft_count6", 32'(count1), 6);
    chk("fwft_head", 32'(rdata1), 32'h61);
    rinc1 = 1;
    tick();
    rinc1 = 0;
    chk("fwft_advance", 32'(rdata1), 32'h62);
    winc1 = 1; wdata1 = 8'h67;
    tick();
    winc1 = 0;
    chk("fwft_count_pre_rst", 32'(count1), 6);
    // asynchronous reset between clock edges
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_count", 32'(count1), 0);
    chk("async_rst_rempty", 32'(rempty1), 1);
    tick();
    rst = 1'b0;
    winc1 = 1; wdata1 = 8'h77;
    tick();
    winc1 = 0;
    chk("post_rst_count", 32'(count1), 1);
    chk("post_rst_rdata", 32'(rdata1), 32'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
